// File: rtl/imem_loader.sv
// Byte-wide instruction memory writer: streams in 32-bit words, emits four
// little-endian byte writes per word, and holds the CPU until the image is loaded.
module imem_loader #(
    parameter int unsigned width = 5
) (
    input  logic             clk,
    input  logic             CLR,
    input  logic             start,
    input  logic [width-2:0] n_words,
    input  logic [31:0]      din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             mem_we,
    output logic [width-1:0] mem_addr,
    output logic [7:0]       mem_wdata,
    output logic             busy,
    output logic             cpu_hold,
    output logic             done,
    output logic             err
);

    localparam int unsigned CW  = width - 1;
    localparam int unsigned CAP = 2 ** (width - 2);
    localparam logic [CW-1:0] CAP_W = CW'(CAP);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_WRITE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [CW-1:0]   idx_q, idx_d;
    logic [1:0]      phase_q, phase_d;
    logic [31:0]     word_q, word_d;
    logic            err_d;

    logic            din_ready_d;
    logic            mem_we_d;
    logic [width-1:0] mem_addr_d;
    logic [7:0]      mem_wdata_d;
    logic            busy_d;
    logic            done_d;

    // State and registered outputs; outputs are precomputed from the next state
    always_ff @(posedge clk) begin
        if (CLR) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            idx_q     <= '0;
            phase_q   <= '0;
            word_q    <= '0;
            err       <= 1'b0;
            din_ready <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            phase_q   <= phase_d;
            word_q    <= word_d;
            err       <= err_d;
            din_ready <= din_ready_d;
            mem_we    <= mem_we_d;
            mem_addr  <= mem_addr_d;
            mem_wdata <= mem_wdata_d;
            busy      <= busy_d;
            done      <= done_d;
        end
    end

    assign cpu_hold = busy;

    // Next-state, datapath and next-output logic
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        phase_d     = phase_q;
        word_d      = word_q;
        err_d       = err;
        din_ready_d = 1'b0;
        mem_we_d    = 1'b0;
        mem_addr_d  = '0;
        mem_wdata_d = '0;
        busy_d      = 1'b0;
        done_d      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (n_words > CAP_W) begin
                        err_d = 1'b1;
                    end else if (n_words == '0) begin
                        err_d   = 1'b0;
                        state_d = S_DONE;
                    end else begin
                        err_d   = 1'b0;
                        cnt_d   = n_words;
                        idx_d   = '0;
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (din_valid) begin
                    word_d  = din;
                    phase_d = 2'd0;
                    state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                if (phase_q == 2'd3) begin
                    idx_d   = idx_q + CW'(1);
                    state_d = ((idx_q + CW'(1)) == cnt_q) ? S_DONE : S_WAIT;
                end else begin
                    phase_d = phase_q + 2'd1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        din_ready_d = (state_d == S_WAIT);
        mem_we_d    = (state_d == S_WRITE);
        busy_d      = (state_d != S_IDLE);
        done_d      = (state_d == S_DONE);

        // idx*4 + phase: low two address bits are the byte phase
        if (mem_we_d) begin
            mem_addr_d = {idx_d[width-3:0], phase_d};
            case (phase_d)
                2'd0:    mem_wdata_d = word_d[7:0];
                2'd1:    mem_wdata_d = word_d[15:8];
                2'd2:    mem_wdata_d = word_d[23:16];
                default: mem_wdata_d = word_d[31:24];
            endcase
        end
    end

endmodule

// File: doc/imem_loader.md
# imem_loader

Writer side of the byte-wide instruction memory that the fetch stage reads as little-endian 32-bit words. It accepts a programmed number of 32-bit words over a valid/ready stream, splits each word into four byte writes at consecutive byte addresses, and holds the CPU (via `cpu_hold`) until the image is complete. It sits between the host or boot source and the write port of the fetch-stage instruction memory.

## Interface

Parameters:
- `width`, 5, byte-address bits of the instruction memory. Capacity is 2**`width` bytes, which is `CAP` = 2**(`width`-2) words.

Ports:
- `clk`  in  1  clock. All state changes on the rising edge.
- `CLR`  in  1  reset. Synchronous, active-high.
- `start`  in  1  begin a load. Sampled only in IDLE.
- `n_words`  in  `width`-1  number of words to load. Latched on the `start` edge. Legal range 0..`CAP`.
- `din`  in  32  word to write. Byte 0 is `din[7:0]`.
- `din_valid`  in  1  `din` is valid.
- `din_ready`  out  1  loader can accept a word.
- `mem_we`  out  1  byte write enable for the instruction memory.
- `mem_addr`  out  `width`  byte address.
- `mem_wdata`  out  8  byte data.
- `busy`  out  1  a load is in progress, i.e. any state other than IDLE.
- `cpu_hold`  out  1  equal to `busy`. Drives the CPU's fetch `CLR`.
- `done`  out  1  one-cycle pulse at the end of a load.
- `err`  out  1  sticky flag: the last `start` requested more than `CAP` words.

## Operation

States: IDLE, WAIT, WRITE, DONE.

Internal registers:
- `cnt`, `width`-1 bits, words remaining target.
- `idx`, `width`-2 bits plus a carry bit, current word index.
- `phase`, 2 bits, byte phase within a word.
- `word`, 32 bits, latched data.

IDLE:
- `start`=1 and `n_words` > `CAP`: set `err`=1 and stay in IDLE.
- `start`=1 and `n_words`=0: clear `err` and go to DONE.
- `start`=1 otherwise: clear `err`, latch `cnt`=`n_words`, set `idx`=0, go to WAIT.

WAIT:
- `din_ready`=1.
- When `din_valid` & `din_ready` are high on an edge: latch `word`=`din`, set `phase`=0, go to WRITE.

WRITE:
- `din_ready`=0 and `mem_we`=1.
- `mem_addr` = `idx`*4 + `phase`, truncated to `width` bits.
- `mem_wdata` = `word[8*phase+7 : 8*phase]`.
- Phases 0 to 2: on the edge, `phase`+1.
- Phase 3: on the edge, `idx`+1. If `idx`+1 == `cnt`, go to DONE; otherwise go to WAIT.

DONE:
- `done`=1 for exactly one cycle, then go to IDLE.

General rules:
- `start` is ignored outside IDLE. `n_words` is ignored after it has been latched.
- `din_valid` is ignored outside WAIT. No word is consumed without a handshake.
- Outputs not named in a state are 0. `mem_addr` and `mem_wdata` are 0 whenever `mem_we`=0.
- Byte order matches fetch. After loading word W at index k, the memory bytes at addresses 4k..4k+3 equal W[7:0], W[15:8], W[23:16], W[31:24]. Fetch at PC=4k therefore returns W.
- A load with `n_words`=`CAP` writes the final byte at address 2**`width`-1. The address never wraps within a legal load.

## Timing

- Reset: when `CLR`=1 on an edge, go to IDLE from any state.
  - `din_ready`, `mem_we`, `mem_addr`, `mem_wdata`, `busy`, `cpu_hold`, `done` and `err` are all 0.
  - `cnt`, `idx` and `phase` are 0.
  - Bytes already written stay in memory. No partial-word rollback.
- Per-word cost: one handshake cycle (minimum) plus 4 write cycles, so at least 5 cycles per word.
- Load latency with `din_valid` held high: `start` edge, then N×5 cycles, then 1 DONE cycle. `busy` is high for 5N+1 cycles.
- `n_words`=0: `busy` and `done` are high for exactly the 1 cycle after the `start` edge.
- `err` sets on the cycle after an oversize `start`. It clears on the next legal `start` or on `CLR`. An oversize `start` never asserts `busy`.
- `CLR` and `start` in the same cycle: `CLR` wins and the loader stays in IDLE.
- `din_valid` dropping mid-WAIT: the loader stalls in WAIT indefinitely. `busy` stays 1 and there is no timeout.

## Test plan

- `width`=5, `start` with `n_words`=2, `din`=0x03020100 then 0x07060504, `din_valid` held high:
  - Required: byte writes 0x00..0x07 to addresses 0..7 in order.
  - `done` pulses at cycle 11 after `start`. `busy` is high for 11 cycles.
- `n_words`=8 (=`CAP`):
  - Required: last write is address 31 with data `din[31:24]` of word 7, then `done`, then IDLE. No write occurs to address 0 after the first word.
- `n_words`=9 → `err`=1, `busy`=0, no `mem_we`. A following `start` with `n_words`=1 clears `err` and loads normally.
- `din_valid` toggled 1-0-0-1 during WAIT:
  - Required: only handshaken words are written. `din_ready`=0 throughout every WRITE cycle.
  - `start` pulsed mid-load has no effect.
- `CLR` asserted during WRITE phase 2 of word 1:
  - Required: the next cycle has all outputs 0 and the loader is in IDLE.
  - A fresh `start` with `n_words`=1 writes addresses 0..3.
- `n_words`=0 → a single-cycle `done` with `busy`=1, and no `mem_we` or `din_ready` assertion.
